// File: rtl/hpdl_text_writer_pkg.sv
// Shared constants and types for the HPDL-1414 text writer: ASCII codes,
// font range bounds, the writer FSM states and the byte classification result.
package hpdl_pkg;

  localparam logic [7:0] CHR_BS    = 8'h08;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_FF    = 8'h0C;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_ESC   = 8'h1B;
  localparam logic [7:0] CHR_SPACE = 8'h20;

  // The HPDL-1414 font covers PRINT_LO..PRINT_HI; LOWER_* folds onto it.
  localparam logic [7:0] PRINT_LO    = 8'h20;
  localparam logic [7:0] PRINT_HI    = 8'h5F;
  localparam logic [7:0] LOWER_LO    = 8'h60;
  localparam logic [7:0] LOWER_HI    = 8'h7E;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ESC_WAIT,
    ST_CLEAR
  } state_t;

  typedef enum logic [2:0] {
    CLS_IGNORE,
    CLS_PRINT,
    CLS_BS,
    CLS_CR,
    CLS_CLEAR,
    CLS_ESC
  } char_class_t;

  typedef struct packed {
    char_class_t cls;
    logic [7:0]  glyph;
  } char_info_t;

endpackage

// File: rtl/hpdl_text_writer_if.sv
// Byte-in / display-memory-write-out bundle of the text writer.
// Echo signals exist only when HPDL_TEXT_ECHO_EN is defined.
interface hpdl_text_writer_if #(
  parameter int ADDR_W = 4
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_data;
  logic [ADDR_W-1:0] cursor;
  logic              busy;
  logic              overflow;

`ifdef HPDL_TEXT_ECHO_EN
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;

  modport master (
    input  rx_valid, rx_data, tx_busy,
    output w_en, w_addr, w_data, cursor, busy, overflow, tx_start, tx_data
  );
  modport slave (
    output rx_valid, rx_data, tx_busy,
    input  w_en, w_addr, w_data, cursor, busy, overflow, tx_start, tx_data
  );
`else
  modport master (
    input  rx_valid, rx_data,
    output w_en, w_addr, w_data, cursor, busy, overflow
  );
  modport slave (
    output rx_valid, rx_data,
    input  w_en, w_addr, w_data, cursor, busy, overflow
  );
`endif
endinterface

// File: rtl/hpdl_text_writer_char_classify.sv
// Combinational byte classifier: maps a received byte to its terminal class
// and the glyph the HPDL-1414 font should show (lowercase folded to upper).
module hpdl_char_classify
  import hpdl_pkg::*;
(
  input  logic [7:0] ch,
  output char_info_t info
);

  always_comb begin
    // NOTE: defaults first so every path assigns info and no latch is inferred.
    info.cls   = CLS_IGNORE;
    info.glyph = ch;
    if (ch >= PRINT_LO && ch <= PRINT_HI) begin
      info.cls = CLS_PRINT;
    end else if (ch >= LOWER_LO && ch <= LOWER_HI) begin
      info.cls   = CLS_PRINT;
      info.glyph = ch - CASE_OFFSET;
    end else begin
      case (ch)
        CHR_BS:         info.cls = CLS_BS;
        CHR_CR:         info.cls = CLS_CR;
        CHR_LF, CHR_FF: info.cls = CLS_CLEAR;
        CHR_ESC:        info.cls = CLS_ESC;
        default:        info.cls = CLS_IGNORE;
      endcase
    end
  end

endmodule

// File: rtl/hpdl_text_writer.sv
// Terminal-style byte stream to HPDL-1414 display memory writer with a
// one-byte pending buffer during clears. Optional echo: HPDL_TEXT_ECHO_EN.
module hpdl_text_writer
  import hpdl_pkg::*;
#(
  parameter int         DEPTH          = 16,
  parameter int         ADDR_W         = 4,
  parameter logic [7:0] BLANK          = CHR_SPACE,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input logic                CLK,
  input logic                RST_N,
  hpdl_text_writer_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] cursor_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic              w_en_q;
  logic [7:0]        w_data_q;
  logic              busy_q;
  logic              overflow_q;
  logic              pend_valid;
  logic [7:0]        pend_data;
  logic              started;

  logic              have_byte;
  logic [7:0]        cur_byte;
  char_info_t        info;

  // The pending byte always wins its dedicated cycle over a fresh arrival.
  assign have_byte = pend_valid || bus.rx_valid;
  assign cur_byte  = pend_valid ? pend_data : bus.rx_data;

  hpdl_char_classify u_classify (
    .ch   (cur_byte),
    .info (info)
  );

`ifdef HPDL_TEXT_ECHO_EN
  logic       tx_start_q;
  logic [7:0] tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      cursor_q   <= '0;
      w_en_q     <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      started    <= 1'b0;
`ifdef HPDL_TEXT_ECHO_EN
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking throughout; later assignments in this block
      // override the single-cycle defaults below.
      started <= 1'b1;
      w_en_q  <= 1'b0;
`ifdef HPDL_TEXT_ECHO_EN
      tx_start_q <= 1'b0;
`endif
      if (!started && CLEAR_ON_RESET) begin
        state    <= ST_CLEAR;
        busy_q   <= 1'b1;
        w_en_q   <= 1'b1;
        w_addr_q <= '0;
        w_data_q <= BLANK;
        if (bus.rx_valid) begin
          pend_valid <= 1'b1;
          pend_data  <= bus.rx_data;
        end
      end else if (state == ST_CLEAR) begin
        if (bus.rx_valid) begin
          if (pend_valid) begin
            overflow_q <= 1'b1;
          end else begin
            pend_valid <= 1'b1;
            pend_data  <= bus.rx_data;
          end
        end
        // w_addr doubles as the clear counter; it already shows this cycle's write.
        if (w_addr_q == LAST_ADDR) begin
          state    <= ST_IDLE;
          busy_q   <= 1'b0;
          cursor_q <= '0;
        end else begin
          w_en_q   <= 1'b1;
          w_addr_q <= w_addr_q + ADDR_W'(1);
          w_data_q <= BLANK;
        end
      end else if (have_byte) begin
        pend_valid <= pend_valid && bus.rx_valid;
        if (pend_valid && bus.rx_valid) begin
          pend_data <= bus.rx_data;
        end
        if (state == ST_ESC_WAIT) begin
          cursor_q <= cur_byte[ADDR_W-1:0];
          state    <= ST_IDLE;
        end else begin
          case (info.cls)
            CLS_PRINT: begin
              w_en_q   <= 1'b1;
              w_addr_q <= cursor_q;
              w_data_q <= info.glyph;
              cursor_q <= cursor_q + ADDR_W'(1);
`ifdef HPDL_TEXT_ECHO_EN
              tx_start_q <= !bus.tx_busy;
              tx_data_q  <= info.glyph;
`endif
            end
            CLS_BS: begin
              if (cursor_q != '0) begin
                w_en_q   <= 1'b1;
                w_addr_q <= cursor_q - ADDR_W'(1);
                w_data_q <= BLANK;
                cursor_q <= cursor_q - ADDR_W'(1);
              end
            end
            CLS_CR: cursor_q <= '0;
            CLS_CLEAR: begin
              state    <= ST_CLEAR;
              busy_q   <= 1'b1;
              w_en_q   <= 1'b1;
              w_addr_q <= '0;
              w_data_q <= BLANK;
            end
            CLS_ESC: state <= ST_ESC_WAIT;
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.w_en     = w_en_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.w_data   = w_data_q;
  assign bus.cursor   = cursor_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_hpdl_text_writer.sv
// Self-checking bench for hpdl_text_writer: fixed vectors, clear/pending
// corner sequences and random bytes against a text-terminal model.
`timescale 1ns/1ps
module tb_hpdl_text_writer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wr_count = 0;
  logic [7:0] shadow [DEPTH];

  logic [7:0] m_mem [DEPTH];
  int         m_cur;
  bit         m_esc;

  typedef struct {
    logic [7:0] din;
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
    logic [3:0] cur;
  } vec_t;
  vec_t vecs[$];

  hpdl_text_writer_if #(.ADDR_W(ADDR_W)) bus ();

  hpdl_text_writer #(
    .DEPTH          (DEPTH),
    .ADDR_W         (ADDR_W),
    .BLANK          (8'h20),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Shadow display memory, filled from the write port.
  always @(negedge clk) begin
    if (rst_n && bus.w_en === 1'b1) begin
      shadow[bus.w_addr] = bus.w_data;
      wr_count++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  // Called right after reset release: expects a full blank sweep.
  task automatic check_clear_run(input string tag);
    for (int k = 0; k < DEPTH; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_wen%0d", tag, k), 32'(bus.w_en), 32'd1);
      check($sformatf("%s_addr%0d", tag, k), 32'(bus.w_addr), 32'(k));
      check($sformatf("%s_data%0d", tag, k), 32'(bus.w_data), 32'h20);
      check($sformatf("%s_busy%0d", tag, k), 32'(bus.busy), 32'd1);
    end
    @(posedge clk);
    #1;
    check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    check({tag, "_wen_end"}, 32'(bus.w_en), 32'd0);
    check({tag, "_cursor_end"}, 32'(bus.cursor), 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("busy_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    #1;
  endtask

  // Terminal rules applied to one byte; returns the number of memory writes.
  task automatic model_byte(input logic [7:0] b, output int nw);
    nw = 0;
    if (m_esc) begin
      m_cur = int'(b) % DEPTH;
      m_esc = 1'b0;
    end else if (b >= 8'h20 && b <= 8'h5F) begin
      m_mem[m_cur] = b;
      m_cur = (m_cur + 1) % DEPTH;
      nw = 1;
    end else if (b >= 8'h60 && b <= 8'h7E) begin
      m_mem[m_cur] = b - 8'h20;
      m_cur = (m_cur + 1) % DEPTH;
      nw = 1;
    end else if (b == 8'h0D) begin
      m_cur = 0;
    end else if (b == 8'h08) begin
      if (m_cur > 0) begin
        m_cur = m_cur - 1;
        m_mem[m_cur] = 8'h20;
        nw = 1;
      end
    end else if (b == 8'h0A || b == 8'h0C) begin
      foreach (m_mem[a]) m_mem[a] = 8'h20;
      m_cur = 0;
      nw = DEPTH;
    end else if (b == 8'h1B) begin
      m_esc = 1'b1;
    end
  endtask

  function automatic logic [7:0] pick();
    int r = $urandom_range(0, 15);
    if (r <= 7)  return 8'($urandom_range(8'h20, 8'h5F));
    if (r <= 10) return 8'($urandom_range(8'h60, 8'h7E));
    if (r == 11) return 8'h08;
    if (r == 12) return 8'h0D;
    if (r == 13) return 8'h1B;
    if (r == 14) return ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h0C;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int nw;
    int w0;
    logic [7:0] b;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
`ifdef HPDL_TEXT_ECHO_EN
    bus.tx_busy  = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_wen", 32'(bus.w_en), 32'd0);
    check("rst_waddr", 32'(bus.w_addr), 32'd0);
    check("rst_wdata", 32'(bus.w_data), 32'd0);
    check("rst_cursor", 32'(bus.cursor), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    check_clear_run("post_reset");

    // Table-driven single-byte vectors: {byte, w_en, addr, data, cursor after}
    vecs.push_back('{8'h48, 1'b1, 4'd0,  8'h48, 4'd1});   // 'H'
    vecs.push_back('{8'h69, 1'b1, 4'd1,  8'h49, 4'd2});   // 'i' -> 'I'
    vecs.push_back('{8'h21, 1'b1, 4'd2,  8'h21, 4'd3});   // '!'
    vecs.push_back('{8'h0D, 1'b0, 4'd0,  8'h00, 4'd0});   // CR
    vecs.push_back('{8'h1B, 1'b0, 4'd0,  8'h00, 4'd0});   // ESC
    vecs.push_back('{8'h07, 1'b0, 4'd0,  8'h00, 4'd7});   // position 7
    vecs.push_back('{8'h5A, 1'b1, 4'd7,  8'h5A, 4'd8});   // 'Z'
    vecs.push_back('{8'h08, 1'b1, 4'd7,  8'h20, 4'd7});   // BS
    vecs.push_back('{8'h0D, 1'b0, 4'd0,  8'h00, 4'd0});   // CR
    vecs.push_back('{8'h08, 1'b0, 4'd0,  8'h00, 4'd0});   // BS at 0
    vecs.push_back('{8'h00, 1'b0, 4'd0,  8'h00, 4'd0});   // ignored
    vecs.push_back('{8'h7F, 1'b0, 4'd0,  8'h00, 4'd0});   // ignored
    vecs.push_back('{8'hC1, 1'b0, 4'd0,  8'h00, 4'd0});   // ignored
    vecs.push_back('{8'h7E, 1'b1, 4'd0,  8'h5E, 4'd1});   // '~' folds
    vecs.push_back('{8'h60, 1'b1, 4'd1,  8'h40, 4'd2});   // '`' folds
    vecs.push_back('{8'h5F, 1'b1, 4'd2,  8'h5F, 4'd3});   // top of font
    vecs.push_back('{8'h1B, 1'b0, 4'd0,  8'h00, 4'd3});   // ESC
    vecs.push_back('{8'h0D, 1'b0, 4'd0,  8'h00, 4'd13});  // CR taken as position
    vecs.push_back('{8'h40, 1'b1, 4'd13, 8'h40, 4'd14});  // '@'
    foreach (vecs[i]) begin
      send_byte(vecs[i].din);
      check($sformatf("vec%0d_wen", i), 32'(bus.w_en), 32'(vecs[i].we));
      if (vecs[i].we) begin
        check($sformatf("vec%0d_addr", i), 32'(bus.w_addr), 32'(vecs[i].addr));
        check($sformatf("vec%0d_data", i), 32'(bus.w_data), 32'(vecs[i].data));
      end
      check($sformatf("vec%0d_cursor", i), 32'(bus.cursor), 32'(vecs[i].cur));
    end

    // Wrap-around: 17 x 'A' from cursor 0
    send_byte(8'h0D);
    for (int k = 0; k < 17; k++) begin
      send_byte(8'h41);
      check($sformatf("wrap_addr%0d", k), 32'(bus.w_addr), 32'(k % DEPTH));
      check($sformatf("wrap_cursor%0d", k), 32'(bus.cursor), 32'((k + 1) % DEPTH));
    end

    // Pending buffer and overflow during an LF clear
    send_byte(8'h0A);
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("pend_busy%0d", k), 32'(bus.busy), 32'd1);
      check($sformatf("pend_addr%0d", k), 32'(bus.w_addr), 32'(k));
      if (k == 5) check("pend_no_overflow_yet", 32'(bus.overflow), 32'd0);
      if (k == 2) begin bus.rx_valid = 1'b1; bus.rx_data = 8'h58; end
      if (k == 5) begin bus.rx_valid = 1'b1; bus.rx_data = 8'h59; end
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
    end
    check("pend_service_wen", 32'(bus.w_en), 32'd0);
    check("pend_service_busy", 32'(bus.busy), 32'd0);
    check("pend_overflow", 32'(bus.overflow), 32'd1);
    @(posedge clk);
    #1;
    check("pend_x_wen", 32'(bus.w_en), 32'd1);
    check("pend_x_addr", 32'(bus.w_addr), 32'd0);
    check("pend_x_data", 32'(bus.w_data), 32'h58);
    check("pend_x_cursor", 32'(bus.cursor), 32'd1);

    // Arrival on the final clear cycle, plus a refill in the service cycle
    send_byte(8'h0C);
    for (int k = 0; k < DEPTH; k++) begin
      if (k == DEPTH - 1) begin bus.rx_valid = 1'b1; bus.rx_data = 8'h51; end
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
    end
    check("last_service_wen", 32'(bus.w_en), 32'd0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h72;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    check("last_q_wen", 32'(bus.w_en), 32'd1);
    check("last_q_addr", 32'(bus.w_addr), 32'd0);
    check("last_q_data", 32'(bus.w_data), 32'h51);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    check("refill_r_mem", 32'(shadow[1]), 32'h52);
    check("refill_r_cursor", 32'(bus.cursor), 32'd2);

    // Random bytes against the terminal model, starting from a known clear
    send_byte(8'h0A);
    wait_idle();
    foreach (m_mem[a]) m_mem[a] = 8'h20;
    m_cur = 0;
    m_esc = 1'b0;
    for (int i = 0; i < 300; i++) begin
      b  = pick();
      w0 = wr_count;
      send_byte(b);
      wait_idle();
      model_byte(b, nw);
      check($sformatf("rand%0d_cursor(byte %0h)", i, b), 32'(bus.cursor), 32'(m_cur));
      check($sformatf("rand%0d_writes(byte %0h)", i, b), 32'(wr_count - w0), 32'(nw));
    end
    foreach (m_mem[a]) check($sformatf("rand_mem%0d", a), 32'(shadow[a]), 32'(m_mem[a]));

    // Reset in the middle of a clear, then a fresh automatic clear
    send_byte(8'h0A);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("midrst_addr_before", 32'(bus.w_addr), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_wen", 32'(bus.w_en), 32'd0);
    check("midrst_waddr", 32'(bus.w_addr), 32'd0);
    check("midrst_wdata", 32'(bus.w_data), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_cursor", 32'(bus.cursor), 32'd0);
    check("midrst_overflow", 32'(bus.overflow), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_clear_run("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
